// File: rtl/r16_modred_drain_if.sv
// Handshake bundle between the R16 pipe-register stages, this reduction
// drain and the butterfly write-back. The slave side belongs to the drain.
interface r16_modred_drain_if #(
    parameter int P_WIDTH = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [P_WIDTH-1:0] A0_in;
    logic               Ac_in;
    logic [P_WIDTH-1:0] N_in;
    logic [P_WIDTH-1:0] D_in;
    logic               out_valid;
    logic               out_ready;
    logic [P_WIDTH-1:0] R_out;
    logic [P_WIDTH-1:0] D_out;
    logic               err_out;
    logic               busy;

    modport master (
        output in_valid, A0_in, Ac_in, N_in, D_in, out_ready,
        input  in_ready, out_valid, R_out, D_out, err_out, busy
    );

    modport slave (
        input  in_valid, A0_in, Ac_in, N_in, D_in, out_ready,
        output in_ready, out_valid, R_out, D_out, err_out, busy
    );
endinterface

// File: rtl/r16_modred_drain.sv
// Radix-16 modular reduction drain: takes a 65-bit {Ac, A0} partial result,
// reduces it into [0, N) by at most MAX_ITER conditional subtractions (one
// per cycle) and returns the reduced word with its untouched tag.
module r16_modred_drain #(
    parameter int P_WIDTH  = 64,
    parameter int MAX_ITER = 3
) (
    input  logic clk,
    input  logic rst,
    r16_modred_drain_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [P_WIDTH:0]   r_v;
    logic [P_WIDTH-1:0] r_nr;
    logic [P_WIDTH-1:0] r_dr;
    logic [CNT_W-1:0]   r_cnt;
    logic [P_WIDTH-1:0] r_r_out;
    logic               r_err;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_accept;
    logic               w_n_zero;
    logic               w_v_lt_n;
    logic               w_cnt_max;
    logic [P_WIDTH:0]   w_n_ext;
    logic [P_WIDTH:0]   w_v_diff;

    // Reduction step decisions: compare is unsigned 65-bit against zero-extended N.
    assign w_n_ext   = {1'b0, r_nr};
    assign w_n_zero  = (r_nr == {P_WIDTH{1'b0}});
    assign w_v_lt_n  = (r_v < w_n_ext);
    assign w_cnt_max = (r_cnt == CNT_W'(MAX_ITER));
    assign w_v_diff  = r_v - w_n_ext;
    assign w_accept  = bus.in_valid & w_in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: REDUCE exits as soon as any stop condition holds.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_REDUCE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_REDUCE: begin
                if (w_n_zero || w_v_lt_n || w_cnt_max) begin
                    w_state_next = S_OUT;
                end else begin
                    w_state_next = S_REDUCE;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_OUT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register; in_ready is held low while reset is asserted.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = ~rst;
            end
            S_REDUCE: begin
                w_busy = 1'b1;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // Datapath: capture on accept, subtract while reducing, hold results through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= {(P_WIDTH+1){1'b0}};
            r_nr    <= {P_WIDTH{1'b0}};
            r_dr    <= {P_WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_r_out <= {P_WIDTH{1'b0}};
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_v   <= {bus.Ac_in, bus.A0_in};
                        r_nr  <= bus.N_in;
                        r_dr  <= bus.D_in;
                        r_cnt <= {CNT_W{1'b0}};
                    end
                end
                S_REDUCE: begin
                    if (w_n_zero) begin
                        r_r_out <= r_v[P_WIDTH-1:0];
                        r_err   <= 1'b1;
                    end else if (w_v_lt_n) begin
                        r_r_out <= r_v[P_WIDTH-1:0];
                        r_err   <= 1'b0;
                    end else if (w_cnt_max) begin
                        r_r_out <= r_v[P_WIDTH-1:0];
                        r_err   <= 1'b1;
                    end else begin
                        r_v   <= w_v_diff;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    r_r_out <= r_r_out;
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.R_out     = r_r_out;
    assign bus.D_out     = r_dr;
    assign bus.err_out   = r_err;
endmodule

// File: tb/tb_r16_modred_drain.sv
// Bench for r16_modred_drain: directed vector table, stall/reset sequences
// and randomized transactions against a division-based reference model.
module tb_r16_modred_drain;
    localparam int W  = 64;
    localparam int MI = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    r16_modred_drain_if #(.P_WIDTH(W)) bus ();

    r16_modred_drain #(.P_WIDTH(W), .MAX_ITER(MI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        ac;
        logic [63:0] a0;
        logic [63:0] n;
        logic [63:0] d;
        logic [63:0] exp_r;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [63:0] r;
        logic        err;
        int          lat;
    } res_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: quotient q = V/N tells how many subtractions bring V below N.
    function automatic res_t model(input logic ac, input logic [63:0] a0, input logic [63:0] n);
        res_t        m;
        logic [64:0] v;
        logic [64:0] nz;
        logic [64:0] q;
        logic [64:0] rem;
        v  = {ac, a0};
        nz = {1'b0, n};
        if (n == 64'd0) begin
            m.r = a0; m.err = 1'b1; m.lat = 1;
        end else begin
            q = v / nz;
            if (q <= 65'(MI)) begin
                rem = v % nz;
                m.r = rem[63:0]; m.err = 1'b0; m.lat = 1 + int'(q);
            end else begin
                rem = v - 65'(MI) * nz;
                m.r = rem[63:0]; m.err = 1'b1; m.lat = 1 + MI;
            end
        end
        return m;
    endfunction

    task automatic run_txn(input logic ac, input logic [63:0] a0, input logic [63:0] n,
                           input logic [63:0] d, input logic [63:0] exp_r, input logic exp_err,
                           input int exp_lat, input int stall, input string name);
        int lat;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.Ac_in     = ac;
        bus.A0_in     = a0;
        bus.N_in      = n;
        bus.D_in      = d;
        bus.out_ready = (stall == 0);
        chk({name, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Ac_in    = ~ac;
        bus.A0_in    = ~a0;
        bus.N_in     = n + 64'd1;
        bus.D_in     = ~d;
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "/R_out"}, bus.R_out, exp_r);
        chk({name, "/D_out"}, bus.D_out, d);
        chk({name, "/err_out"}, 64'(bus.err_out), 64'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({name, "/stall_valid"}, 64'(bus.out_valid), 64'd1);
            chk({name, "/stall_R"}, bus.R_out, exp_r);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "/done_valid"}, 64'(bus.out_valid), 64'd0);
        chk({name, "/done_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        res_t        m;
        logic [64:0] v;
        logic [63:0] n;
        logic [63:0] rem;
        int          sel;
        int          stall;

        vecs[0] = '{1'b0, 64'd5,      64'd17,                  64'hAB, 64'd5,                  1'b0, 1};
        vecs[1] = '{1'b1, 64'd0,      64'hFFFFFFFF00000001,    64'h11, 64'h00000000FFFFFFFF,   1'b0, 2};
        vecs[2] = '{1'b0, 64'd100,    64'd7,                   64'h22, 64'd79,                 1'b1, 4};
        vecs[3] = '{1'b0, 64'h1234,   64'd0,                   64'h33, 64'h1234,               1'b1, 1};
        vecs[4] = '{1'b0, 64'd21,     64'd7,                   64'h44, 64'd0,                  1'b0, 4};
        vecs[5] = '{1'b0, 64'd28,     64'd7,                   64'h55, 64'd7,                  1'b1, 4};
        vecs[6] = '{1'b0, 64'd7,      64'd7,                   64'h66, 64'd0,                  1'b0, 2};
        vecs[7] = '{1'b1, {64{1'b1}}, 64'd1,                   64'h77, 64'hFFFFFFFFFFFFFFFC,   1'b1, 4};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.Ac_in     = 1'b0;
        bus.A0_in     = 64'd0;
        bus.N_in      = 64'd0;
        bus.D_in      = 64'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset/busy",      64'(bus.busy),      64'd0);
        chk("reset/in_ready",  64'(bus.in_ready),  64'd0);
        chk("reset/R_out",     bus.R_out,          64'd0);
        chk("reset/D_out",     bus.D_out,          64'd0);
        chk("reset/err_out",   64'(bus.err_out),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release/in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].ac, vecs[i].a0, vecs[i].n, vecs[i].d, vecs[i].exp_r,
                    vecs[i].exp_err, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));
        end

        // Output stall with in_valid held high carrying new data.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.Ac_in = 1'b0; bus.A0_in = 64'd5; bus.N_in = 64'd17;
        bus.D_in = 64'hAB; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.A0_in = 64'd3; bus.N_in = 64'd10; bus.D_in = 64'h5A;
        @(posedge clk); #1;
        chk("stall/out_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall/R_out",    bus.R_out,          64'd5);
            chk("stall/D_out",    bus.D_out,          64'hAB);
            chk("stall/err_out",  64'(bus.err_out),   64'd0);
            chk("stall/in_ready", 64'(bus.in_ready),  64'd0);
            chk("stall/valid",    64'(bus.out_valid), 64'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall/hs_valid", 64'(bus.out_valid), 64'd0);
        chk("stall/hs_busy",  64'(bus.busy),      64'd0);
        chk("stall/hs_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        chk("stall/second_accept", 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stall/second_valid", 64'(bus.out_valid), 64'd1);
        chk("stall/second_R",     bus.R_out,          64'd3);
        chk("stall/second_D",     bus.D_out,          64'h5A);
        @(posedge clk); #1;
        chk("stall/second_done", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a multi-cycle reduction.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.Ac_in = 1'b0; bus.A0_in = 64'd100; bus.N_in = 64'd7;
        bus.D_in = 64'hC3; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst/busy",      64'(bus.busy),      64'd0);
        chk("midrst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst/R_out",     bus.R_out,          64'd0);
        chk("midrst/D_out",     bus.D_out,          64'd0);
        chk("midrst/in_ready",  64'(bus.in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst/release_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst/no_output", 64'(bus.out_valid), 64'd0);
        run_txn(1'b0, 64'd5, 64'd17, 64'hAB, 64'd5, 1'b0, 1, 0, "midrst/fresh");

        // Randomized transactions against the reference model.
        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 15));
            if (sel == 0) begin
                n = 64'd0;
            end else if (sel < 6) begin
                n = 64'($urandom_range(1, 1000));
            end else begin
                n = {$urandom, $urandom};
                if (n == 64'd0) n = 64'd1;
            end
            if (n == 64'd0) begin
                v = {1'($urandom), $urandom, $urandom};
            end else begin
                sel = int'($urandom_range(0, 3));
                if (sel == 0)      rem = 64'd0;
                else if (sel == 1) rem = n - 64'd1;
                else               rem = {$urandom, $urandom} % n;
                v = 65'($urandom_range(0, 5)) * {1'b0, n} + {1'b0, rem};
            end
            m = model(v[64], v[63:0], n);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(v[64], v[63:0], n, {$urandom, $urandom}, m.r, m.err, m.lat, stall,
                    $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
